// File: rtl/tl_arb_pkg.sv
// Shared types for the toggle/load bank arbiter: command opcodes and FSM states.
package tl_arb_pkg;

  typedef enum logic [1:0] {
    OP_LOAD     = 2'b00,
    OP_TOGGLE   = 2'b01,
    OP_TOGGLE_N = 2'b10,
    OP_NOP      = 2'b11
  } op_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/tl_reg.sv
// Shared WIDTH-bit bank register: synchronous load or masked toggle, load wins.
module tl_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ld_en,
  input  logic             tg_en,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] mask,
  output logic [WIDTH-1:0] Q
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      Q <= '0;
    end else if (ld_en) begin
      Q <= d;
    end else if (tg_en) begin
      Q <= Q ^ mask;
    end
  end

endmodule

// File: rtl/tl_bank_arbiter.sv
// Round-robin arbiter that serialises load/toggle/burst-toggle commands from
// NREQ requesters onto one shared register bank.
module tl_bank_arbiter
  import tl_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LENW  = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] data,
  input  logic [LENW*NREQ-1:0]  len,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      F
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state, state_n;
  logic [PW-1:0]     ptr, ptr_n;
  logic [PW-1:0]     own, own_n;
  logic [LENW-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]  mask, mask_n;
  logic [NREQ-1:0]   gnt_n, done_n;
  logic              busy_n;

  logic              pick_vld_c;
  logic [PW-1:0]     pick_c, idx_c;
  op_t               sel_op_c;
  logic [WIDTH-1:0]  sel_data_c;
  logic [LENW-1:0]   sel_len_c;
  logic              ld_en_c, tg_en_c;
  logic [WIDTH-1:0]  tg_mask_c;

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] w);
    return PW'((32'(w) + 32'd1) % NREQ);
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] w);
    return NREQ'(1) << w;
  endfunction

  // First requester at or after the round-robin pointer, wrapping.
  always_comb begin
    pick_vld_c = 1'b0;
    pick_c     = '0;
    idx_c      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx_c = PW'((32'(ptr) + k) % NREQ);
      if (!pick_vld_c && req[idx_c]) begin
        pick_vld_c = 1'b1;
        pick_c     = idx_c;
      end
    end
  end

  // Winner's command fields.
  always_comb begin
    sel_op_c   = OP_NOP;
    sel_data_c = '0;
    sel_len_c  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_c == PW'(i)) begin
        sel_op_c   = op_t'(op[2*i +: 2]);
        sel_data_c = data[WIDTH*i +: WIDTH];
        sel_len_c  = len[LENW*i +: LENW];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      ptr   <= '0;
      own   <= '0;
      cnt   <= '0;
      mask  <= '0;
      gnt   <= '0;
      done  <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      own   <= own_n;
      cnt   <= cnt_n;
      mask  <= mask_n;
      gnt   <= gnt_n;
      done  <= done_n;
      busy  <= busy_n;
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    own_n     = own;
    cnt_n     = cnt;
    mask_n    = mask;
    gnt_n     = '0;
    done_n    = '0;
    busy_n    = 1'b0;
    ld_en_c   = 1'b0;
    tg_en_c   = 1'b0;
    tg_mask_c = sel_data_c;
    case (state)
      S_IDLE: begin
        if (pick_vld_c) begin
          gnt_n = onehot(pick_c);
          if (sel_op_c == OP_TOGGLE_N && sel_len_c != '0) begin
            state_n = S_BURST;
            busy_n  = 1'b1;
            cnt_n   = sel_len_c;
            mask_n  = sel_data_c;
            own_n   = pick_c;
          end else begin
            // Zero-length burst degenerates to an acknowledge-only command.
            done_n  = onehot(pick_c);
            ptr_n   = ptr_after(pick_c);
            ld_en_c = (sel_op_c == OP_LOAD);
            tg_en_c = (sel_op_c == OP_TOGGLE);
          end
        end
      end
      S_BURST: begin
        tg_en_c   = 1'b1;
        tg_mask_c = mask;
        cnt_n     = cnt - LENW'(1);
        if (cnt == LENW'(1)) begin
          done_n  = onehot(own);
          ptr_n   = ptr_after(own);
          state_n = S_IDLE;
        end else begin
          gnt_n  = onehot(own);
          busy_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  tl_reg #(.WIDTH(WIDTH)) u_reg (
    .CLK   (CLK),
    .RST_N (RST_N),
    .ld_en (ld_en_c),
    .tg_en (tg_en_c),
    .d     (sel_data_c),
    .mask  (tg_mask_c),
    .Q     (F)
  );

endmodule
